// File: rtl/timer_bcd_param.sv
// Day/hour/minute/second BCD timer: prescaled tick, up/down count, run/pause, validated load.
// Optional registered seven-segment outputs when TIMER_SSD_EN is defined.
module timer_bcd_param #(
  parameter int unsigned CLK_DIV = 50_000_000,
  parameter int unsigned DAY_MAX = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        dir,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [7:0]  load_day,
  input  logic [7:0]  load_hour,
  input  logic [7:0]  load_min,
  input  logic [7:0]  load_sec,
  output logic        load_err,
  output logic [7:0]  bcd_day,
  output logic [7:0]  bcd_hour,
  output logic [7:0]  bcd_min,
  output logic [7:0]  bcd_sec,
  output logic        tick,
`ifdef TIMER_SSD_EN
  output logic [55:0] ssd,
`endif
  output logic        wrap
);

  localparam logic [31:0] DIV_TC      = 32'(CLK_DIV - 1);
  localparam logic [7:0]  DAY_MAX_BCD = {4'(DAY_MAX / 10), 4'(DAY_MAX % 10)};

  typedef enum logic [1:0] {S_SYNC, S_STOP, S_RUN, S_LOAD} state_t;

  state_t      r_state, w_next;
  logic        r_sync;
  logic [31:0] r_presc;
  logic [7:0]  r_day, r_hour, r_min, r_sec;
  logic        r_tick, r_wrap, r_err;

  logic [8:0]  w_s, w_m, w_h, w_d;
  logic        w_xfer, w_tc, w_ld_ok, w_nib_ok, w_wrap_n;
  logic        w_c_m, w_c_h, w_c_d;

  // Result bit 8 is the carry/borrow out of the field.
  function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v == max)              bcd_inc = 9'h100;
    else if (v[3:0] == 4'd9)   bcd_inc = {1'b0, v[7:4] + 4'd1, 4'd0};
    else                       bcd_inc = {1'b0, v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [8:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
    if (v == 8'h00)            bcd_dec = {1'b1, max};
    else if (v[3:0] == 4'd0)   bcd_dec = {1'b0, v[7:4] - 4'd1, 4'd9};
    else                       bcd_dec = {1'b0, v[7:4], v[3:0] - 4'd1};
  endfunction

  assign w_s = dir ? bcd_dec(r_sec,  8'h59)      : bcd_inc(r_sec,  8'h59);
  assign w_m = dir ? bcd_dec(r_min,  8'h59)      : bcd_inc(r_min,  8'h59);
  assign w_h = dir ? bcd_dec(r_hour, 8'h23)      : bcd_inc(r_hour, 8'h23);
  assign w_d = dir ? bcd_dec(r_day,  DAY_MAX_BCD) : bcd_inc(r_day,  DAY_MAX_BCD);

  assign w_c_m    = w_s[8];
  assign w_c_h    = w_c_m & w_m[8];
  assign w_c_d    = w_c_h & w_h[8];
  assign w_wrap_n = w_c_d & w_d[8];

  assign w_nib_ok = (load_day[7:4]  <= 4'd9) && (load_day[3:0]  <= 4'd9) &&
                    (load_hour[7:4] <= 4'd9) && (load_hour[3:0] <= 4'd9) &&
                    (load_min[7:4]  <= 4'd9) && (load_min[3:0]  <= 4'd9) &&
                    (load_sec[7:4]  <= 4'd9) && (load_sec[3:0]  <= 4'd9);
  // With every nibble a decimal digit, packed comparison orders like the value.
  assign w_ld_ok  = w_nib_ok && (load_sec <= 8'h59) && (load_min <= 8'h59) &&
                    (load_hour <= 8'h23) && (load_day <= DAY_MAX_BCD);

  assign load_ready = (r_state == S_STOP) || (r_state == S_RUN);
  assign w_xfer     = load_valid && load_ready;
  assign w_tc       = (r_state == S_RUN) && (r_presc == DIV_TC);

  // r_sync is the first synchroniser stage; the state register is the second.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync  <= 1'b0;
      r_state <= S_SYNC;
    end else begin
      r_sync  <= 1'b1;
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_SYNC:  if (r_sync) w_next = S_STOP;
      S_STOP:  if (w_xfer) w_next = S_LOAD; else if (run)  w_next = S_RUN;
      S_RUN:   if (w_xfer) w_next = S_LOAD; else if (!run) w_next = S_STOP;
      S_LOAD:  w_next = run ? S_RUN : S_STOP;
      default: w_next = S_SYNC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= 32'd0;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
      r_err   <= 1'b0;
      r_day   <= 8'h00;
      r_hour  <= 8'h00;
      r_min   <= 8'h00;
      r_sec   <= 8'h00;
    end else begin
      r_tick <= w_tc && !w_xfer;
      r_wrap <= w_tc && !w_xfer && w_wrap_n;
      r_err  <= w_xfer && !w_ld_ok;
      if (w_xfer)                r_presc <= 32'd0;
      else if (w_tc)             r_presc <= 32'd0;
      else if (r_state == S_RUN) r_presc <= r_presc + 32'd1;
      // A load beats a coincident terminal count.
      if (w_xfer) begin
        if (w_ld_ok) begin
          r_day  <= load_day;
          r_hour <= load_hour;
          r_min  <= load_min;
          r_sec  <= load_sec;
        end
      end else if (w_tc) begin
        r_sec <= w_s[7:0];
        if (w_c_m) r_min  <= w_m[7:0];
        if (w_c_h) r_hour <= w_h[7:0];
        if (w_c_d) r_day  <= w_d[7:0];
      end
    end
  end

  assign bcd_day  = r_day;
  assign bcd_hour = r_hour;
  assign bcd_min  = r_min;
  assign bcd_sec  = r_sec;
  assign tick     = r_tick;
  assign wrap     = r_wrap;
  assign load_err = r_err;

`ifdef TIMER_SSD_EN
  logic [55:0] r_ssd;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1111110;
      4'd1:    seg7 = 7'b0110000;
      4'd2:    seg7 = 7'b1101101;
      4'd3:    seg7 = 7'b1111001;
      4'd4:    seg7 = 7'b0110011;
      4'd5:    seg7 = 7'b1011011;
      4'd6:    seg7 = 7'b1011111;
      4'd7:    seg7 = 7'b1110000;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1111011;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ssd <= {8{7'b1111110}};
    else     r_ssd <= {seg7(r_day[7:4]),  seg7(r_day[3:0]),  seg7(r_hour[7:4]), seg7(r_hour[3:0]),
                       seg7(r_min[7:4]),  seg7(r_min[3:0]),  seg7(r_sec[7:4]),  seg7(r_sec[3:0])};
  end

  assign ssd = r_ssd;
`endif

endmodule

// File: doc/timer_bcd_param.md
# timer_bcd_param

Parametrised day/hour/minute/second timer; successor to the fixed seven-segment timer top. Adds a configurable clock prescaler, a configurable day range (two BCD day digits), up/down counting, run/pause and a validated load handshake. The block sits between the board clock/reset and the display driver. It exports BCD digits, tick and wrap pulses, and optionally registered seven-segment patterns.

## Interface
- CLK_DIV, 50_000_000: clk cycles per one-second tick; legal range 2..2^32-1.
- DAY_MAX, 9: highest day value; legal range 1..99.
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous active-high reset.
- run  in  1  1 = count, 0 = pause.
- dir  in  1  0 = count up, 1 = count down; sampled at each tick.
- load_valid  in  1  load request, held until accepted.
- load_ready  out  1  load acceptance; a transfer occurs when load_valid && load_ready.
- load_day, load_hour, load_min, load_sec  in  8 each  packed BCD {tens, units}.
- load_err  out  1  1-cycle pulse when an accepted load is rejected as invalid.
- bcd_day, bcd_hour, bcd_min, bcd_sec  out  8 each  packed BCD current time.
- tick  out  1  1-cycle pulse in the cycle the time outputs take a new counted value.
- wrap  out  1  1-cycle pulse coincident with tick on a full rollover or underflow.
- ssd  out  56  only with TIMER_SSD_EN; 8 digits × 7 bits, MSB first: day_h, day_l, hour_h, hour_l, min_h, min_l, sec_h, sec_l. Segment order is a..g, bit6 = a, active-high; 0 = 7'b1111110.

## Operation
- Reset: assertion is asynchronous. Deassertion is synchronised internally by a 2-flop synchroniser, and the block leaves SYNC 2 clk edges after rst falls.
- FSM states are SYNC, STOP, RUN and LOAD.
  - SYNC → STOP after the synchroniser releases.
  - STOP ↔ RUN follows `run`, evaluated every cycle.
  - STOP/RUN → LOAD on a transfer.
  - LOAD → RUN if run = 1, otherwise STOP, after exactly 1 cycle.
- load_ready = 1 only in STOP or RUN. It is 0 in SYNC and LOAD.
- Prescaler: a 32-bit counter 0..CLK_DIV-1.
  - Increments only in RUN.
  - Holds its value in STOP, so a pause does not lose the partial second.
  - Cleared by reset and by a transfer.
  - When it reaches CLK_DIV-1 it returns to 0 and a tick is issued.
- Up count:
  - sec 59→00 carries to min.
  - min 59→00 carries to hour.
  - hour 23→00 carries to day.
  - day DAY_MAX→00 with all lower fields rolling asserts wrap.
- Down count:
  - sec 00→59 borrows from min.
  - min 00→59 borrows from hour.
  - hour 00→23 borrows from day.
  - 00:00:00:00 → DAY_MAX:23:59:59 asserts wrap.
- All arithmetic is per-digit BCD. A units digit never holds a value above 9.
- Load validation:
  - Every nibble must be ≤ 9.
  - sec ≤ 59, min ≤ 59, hour ≤ 23, day ≤ DAY_MAX.
  - If the load is valid, the time registers take the load values in the LOAD cycle.
  - If the load is invalid, the time is unchanged and load_err pulses in the LOAD cycle.
  - Either way, the prescaler is cleared.
- Simultaneous events:
  - Transfer in the same cycle as a prescaler terminal count: the load wins, and no tick or wrap is issued for that second.
  - dir change mid-second: takes effect at the next tick.
  - rst during LOAD: the block returns to SYNC immediately, and the load is lost.

## Timing
- Reset values:
  - bcd_* = 8'h00.
  - tick, wrap, load_err = 0.
  - load_ready = 0.
  - ssd = eight copies of 7'b1111110.
- Tick latency: the first tick arrives CLK_DIV cycles after entering RUN from a cleared prescaler. tick, wrap and the new bcd_* values are all registered and change on the same edge.
- Load latency: the transfer is at edge N. bcd_* show the loaded value and load_err is valid after edge N+1, in the LOAD cycle. load_ready returns to 1 after edge N+2.
- ssd is registered from bcd_*, so it lags bcd_* by exactly 1 cycle.

## Configuration
- TIMER_SSD_EN defined:
  - The `ssd` port and 8 registered BCD-to-segment encoders are present.
  - ssd lags bcd_* by 1 cycle.
- TIMER_SSD_EN undefined:
  - No `ssd` port and no encoder logic.
  - All other behaviour is identical.

## Test plan
All scenarios use CLK_DIV = 4 and DAY_MAX = 2.
- Reset release:
  - Stimulus: rst high for 3 cycles, then low.
  - Response: bcd_* = 00 throughout. load_ready rises 2 edges after rst falls. ssd = 1111110 ×8.
- Up count with pause:
  - Stimulus: run = 1 for 12 cycles, then 0 for 5, then 1.
  - Response: bcd_sec = 03 after 12 cycles, held during the pause. The next tick comes 4 cycles after resume, giving sec = 04.
- Full up rollover:
  - Stimulus: load 02:23:59:59, then run with dir = 0.
  - Response: the first tick gives 00:00:00:00 with wrap = 1. The next tick gives 00:00:00:01 with wrap = 0.
- Down underflow:
  - Stimulus: load 00:00:00:00, then dir = 1.
  - Response: the first tick gives 02:23:59:59 with wrap = 1. The next tick gives 02:23:59:58.
- Invalid load:
  - Stimulus: load_min = 8'h60 while the time is 00:01:02:03.
  - Response: load_err pulses for 1 cycle. Time is unchanged. The prescaler is cleared, so the next tick comes 4 cycles after LOAD.
- Load vs tick collision:
  - Stimulus: assert load_valid in the prescaler's terminal cycle with value 01:02:03:04.
  - Response: bcd_* = 01:02:03:04 with no tick in that cycle. The next tick gives 01:02:03:05 four cycles later.
